// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory access unit: state encoding, default widths
// and the address bits that mark a request as rejected.
package mem_access_pkg;

    localparam int DATA_W       = 16;
    localparam int ADDR_W       = 14;
    localparam int MISALIGN_BIT = 0;
    localparam int RANGE_BIT    = 15;

    localparam logic [15:0] ERR_COUNT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_DATA = 2'd1,
        ST_RSP     = 2'd2
    } state_e;

    // Odd byte addresses and anything at or above 0x8000 are rejected.
    function automatic logic addr_is_error(input logic [15:0] addr);
        return addr[MISALIGN_BIT] | addr[RANGE_BIT];
    endfunction

endpackage

// File: rtl/mem_rsp_hold.sv
// One-entry response hold register; keeps a response stable while the
// consumer is not ready to take it.
module mem_rsp_hold
    import mem_access_pkg::*;
#(
    parameter int DATA_W = mem_access_pkg::DATA_W
) (
    input  logic              clka,
    input  logic              rsta,
    input  logic              load_en,
    input  logic [DATA_W-1:0] rdata_in,
    input  logic              err_in,
    output logic [DATA_W-1:0] rdata_out,
    output logic              err_out
);

    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        if (load_en) begin
            rdata_d = rdata_in;
            err_d   = err_in;
        end
    end

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign rdata_out = rdata_q;
    assign err_out   = err_q;

endmodule

// File: rtl/mem_access_unit.sv
// Processor-to-synchronous-memory bridge: one outstanding request, read data
// one cycle after acceptance, rejected requests answered with an error.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int DATA_W = mem_access_pkg::DATA_W,
    parameter int ADDR_W = mem_access_pkg::ADDR_W
) (
    input  logic              clka,
    input  logic              rsta,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [15:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [15:0]       err_count,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       err_count_q, err_count_d;

    logic              req_err;
    logic [ADDR_W-1:0] req_word;

    logic              hold_load;
    logic [DATA_W-1:0] hold_rdata_in, hold_rdata;
    logic              hold_err_in, hold_err;

    assign req_err  = addr_is_error(req_addr);
    assign req_word = req_addr[ADDR_W:1];

    mem_rsp_hold #(
        .DATA_W (DATA_W)
    ) u_hold (
        .clka      (clka),
        .rsta      (rsta),
        .load_en   (hold_load),
        .rdata_in  (hold_rdata_in),
        .err_in    (hold_err_in),
        .rdata_out (hold_rdata),
        .err_out   (hold_err)
    );

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        err_count_d   = err_count_q;
        hold_load     = 1'b0;
        hold_rdata_in = '0;
        hold_err_in   = 1'b0;
        req_ready     = 1'b0;
        rsp_valid     = 1'b0;
        rsp_rdata     = '0;
        rsp_err       = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = addr_q;
        mem_din       = '0;

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                mem_addr  = req_word;
                mem_din   = req_wdata;
                mem_we    = req_valid & req_we & ~req_err & ~rsta;
                if (req_valid) begin
                    addr_d = req_word;
                    if (req_err) begin
                        hold_load   = 1'b1;
                        hold_err_in = 1'b1;
                        state_d     = ST_RSP;
                        if (err_count_q != ERR_COUNT_MAX) begin
                            err_count_d = err_count_q + 16'd1;
                        end
                    end else if (req_we) begin
                        hold_load = 1'b1;
                        state_d   = ST_RSP;
                    end else begin
                        state_d = ST_RD_DATA;
                    end
                end
            end
            // Read data comes straight from the memory; park it if the consumer stalls.
            ST_RD_DATA: begin
                rsp_valid = 1'b1;
                rsp_rdata = mem_dout;
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_load     = 1'b1;
                    hold_rdata_in = mem_dout;
                    state_d       = ST_RSP;
                end
            end
            ST_RSP: begin
                rsp_valid = 1'b1;
                rsp_rdata = hold_rdata;
                rsp_err   = hold_err;
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            err_count_q <= err_count_d;
        end
    end

    assign err_count = err_count_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized
// traffic compared against a word-array reference model.
module tb_mem_access_unit;

    logic        clka = 1'b0;
    logic        rsta;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic [15:0] err_count;
    logic        mem_we;
    logic [13:0] mem_addr;
    logic [15:0] mem_din;
    logic [15:0] mem_dout;

    logic [15:0] mem     [0:16383];
    logic [15:0] ref_mem [0:16383];
    int          exp_err_count;

    int n_compared   = 0;
    int n_mismatched = 0;

    typedef struct {
        logic        ready_seen;
        logic        we_seen;
        logic [13:0] addr_seen;
        logic        got_rsp;
        int          latency;
        logic [15:0] rdata;
        logic        err;
        logic [13:0] rsp_addr;
        logic        stable;
        logic        idle_after;
    } obs_t;

    always #5 clka = ~clka;

    mem_access_unit dut (
        .clka      (clka),
        .rsta      (rsta),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .err_count (err_count),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout)
    );

    // Synchronous memory with registered read data.
    always @(posedge clka) begin
        if (mem_we) mem[mem_addr] <= mem_din;
        mem_dout <= mem[mem_addr];
    end

    // Reference model: rejected requests count as errors, valid writes land in ref_mem.
    function automatic logic model_is_err(input logic [15:0] addr);
        return (addr % 2 == 1) || (addr >= 16'h8000);
    endfunction

    function automatic logic [15:0] model_rdata(input logic we, input logic [15:0] addr);
        if (we || model_is_err(addr)) return 16'd0;
        return ref_mem[addr / 2];
    endfunction

    task automatic model_apply(input logic we, input logic [15:0] addr, input logic [15:0] wdata);
        if (model_is_err(addr)) begin
            if (exp_err_count < 65535) exp_err_count++;
        end else if (we) begin
            ref_mem[addr / 2] = wdata;
        end
    endtask

    task automatic do_txn(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                          input int stall, output obs_t o);
        o = '{default: '0};
        @(negedge clka);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        rsp_ready = (stall == 0);
        #1;
        o.ready_seen = req_ready;
        o.we_seen    = mem_we;
        o.addr_seen  = mem_addr;
        @(posedge clka);
        @(negedge clka);
        req_valid = 1'b0;
        req_we    = 1'b0;
        o.latency = 1;
        while (!rsp_valid && o.latency < 4) begin
            @(negedge clka);
            o.latency++;
        end
        if (rsp_valid) begin
            o.got_rsp  = 1'b1;
            o.rdata    = rsp_rdata;
            o.err      = rsp_err;
            o.rsp_addr = mem_addr;
            o.stable   = (req_ready === 1'b0);
            for (int i = 0; i < stall; i++) begin
                @(negedge clka);
                if (rsp_valid !== 1'b1 || rsp_rdata !== o.rdata || rsp_err !== o.err ||
                    req_ready !== 1'b0)
                    o.stable = 1'b0;
            end
            rsp_ready = 1'b1;
            @(negedge clka);
            rsp_ready = 1'b0;
            o.idle_after = (rsp_valid === 1'b0) && (req_ready === 1'b1);
        end else begin
            rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rsta      = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 16'h0004;
        req_wdata = 16'h1234;
        rsp_ready = 1'b0;
        exp_err_count = 0;
        repeat (2) @(negedge clka);
        #1;
        n_compared++;
        if (mem_we !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_mem_we: got %b expected 0", mem_we);
        end
        n_compared++;
        if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 16'd0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_rsp: got valid=%b err=%b rdata=%h expected 0/0/0000",
                     rsp_valid, rsp_err, rsp_rdata);
        end
        n_compared++;
        if (err_count !== 16'd0 || req_ready !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL reset_state: got err_count=%0d req_ready=%b expected 0/1",
                     err_count, req_ready);
        end
        req_valid = 1'b0;
        req_we    = 1'b0;
        rsta      = 1'b0;
        @(negedge clka);
    endtask

    task automatic test_write_read();
        obs_t o;
        do_txn(1'b1, 16'h0004, 16'd420, 0, o);
        model_apply(1'b1, 16'h0004, 16'd420);
        n_compared++;
        if (o.we_seen !== 1'b1 || o.addr_seen !== 14'd2 || o.ready_seen !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL wr_pulse: got we=%b addr=%0d ready=%b expected 1/2/1",
                     o.we_seen, o.addr_seen, o.ready_seen);
        end
        n_compared++;
        if (o.got_rsp !== 1'b1 || o.err !== 1'b0 || o.rdata !== 16'd0) begin
            n_mismatched++;
            $display("[TB] FAIL wr_rsp: got rsp=%b err=%b rdata=%0d expected 1/0/0",
                     o.got_rsp, o.err, o.rdata);
        end
        do_txn(1'b0, 16'h0004, 16'd0, 0, o);
        n_compared++;
        if (o.rdata !== model_rdata(1'b0, 16'h0004) || o.latency != 1 || o.we_seen !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL rd_data: got rdata=%0d lat=%0d we=%b expected %0d/1/0",
                     o.rdata, o.latency, o.we_seen, model_rdata(1'b0, 16'h0004));
        end
        n_compared++;
        if (o.idle_after !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL rd_idle_after: got %b expected 1", o.idle_after);
        end
    endtask

    task automatic test_stall();
        obs_t o;
        do_txn(1'b1, 16'h0008, 16'd69, 0, o);
        model_apply(1'b1, 16'h0008, 16'd69);
        do_txn(1'b0, 16'h0008, 16'd0, 3, o);
        n_compared++;
        if (o.rdata !== 16'd69 || o.err !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL stall_data: got rdata=%0d err=%b expected 69/0", o.rdata, o.err);
        end
        n_compared++;
        if (o.stable !== 1'b1 || o.got_rsp !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL stall_hold: got stable=%b rsp=%b expected 1/1", o.stable, o.got_rsp);
        end
    endtask

    task automatic test_misaligned();
        obs_t o;
        do_txn(1'b0, 16'h0005, 16'd0, 1, o);
        model_apply(1'b0, 16'h0005, 16'd0);
        n_compared++;
        if (o.we_seen !== 1'b0 || o.err !== 1'b1 || o.rdata !== 16'd0) begin
            n_mismatched++;
            $display("[TB] FAIL misaligned_rsp: got we=%b err=%b rdata=%0d expected 0/1/0",
                     o.we_seen, o.err, o.rdata);
        end
        n_compared++;
        if (err_count !== 16'(exp_err_count)) begin
            n_mismatched++;
            $display("[TB] FAIL misaligned_count: got %0d expected %0d", err_count, exp_err_count);
        end
    endtask

    task automatic test_out_of_range();
        obs_t o;
        do_txn(1'b1, 16'h8000, 16'hDEAD, 0, o);
        model_apply(1'b1, 16'h8000, 16'hDEAD);
        n_compared++;
        if (o.we_seen !== 1'b0 || o.err !== 1'b1 || o.rdata !== 16'd0) begin
            n_mismatched++;
            $display("[TB] FAIL range_rsp: got we=%b err=%b rdata=%0d expected 0/1/0",
                     o.we_seen, o.err, o.rdata);
        end
        n_compared++;
        if (err_count !== 16'(exp_err_count) || mem[0] !== ref_mem[0]) begin
            n_mismatched++;
            $display("[TB] FAIL range_count_mem: got count=%0d mem0=%h expected %0d/%h",
                     err_count, mem[0], exp_err_count, ref_mem[0]);
        end
    endtask

    task automatic test_reset_abort();
        obs_t o;
        @(negedge clka);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 16'h0004;
        rsp_ready = 1'b0;
        @(negedge clka);
        req_valid = 1'b0;
        n_compared++;
        if (rsp_valid !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL abort_pre: got rsp_valid=%b expected 1", rsp_valid);
        end
        #2 rsta = 1'b1;
        exp_err_count = 0;
        #1;
        n_compared++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || err_count !== 16'd0) begin
            n_mismatched++;
            $display("[TB] FAIL abort_async: got valid=%b ready=%b count=%0d expected 0/1/0",
                     rsp_valid, req_ready, err_count);
        end
        @(negedge clka);
        rsta = 1'b0;
        do_txn(1'b0, 16'h0004, 16'd0, 0, o);
        n_compared++;
        if (o.rdata !== model_rdata(1'b0, 16'h0004) || o.err !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL abort_reread: got rdata=%0d err=%b expected %0d/0",
                     o.rdata, o.err, model_rdata(1'b0, 16'h0004));
        end
    endtask

    task automatic test_top_word();
        obs_t o;
        do_txn(1'b1, 16'h7FFE, 16'hBEEF, 0, o);
        model_apply(1'b1, 16'h7FFE, 16'hBEEF);
        n_compared++;
        if (o.we_seen !== 1'b1 || o.addr_seen !== 14'd16383) begin
            n_mismatched++;
            $display("[TB] FAIL top_wr: got we=%b addr=%0d expected 1/16383", o.we_seen, o.addr_seen);
        end
        do_txn(1'b0, 16'h7FFE, 16'd0, 1, o);
        n_compared++;
        if (o.rdata !== 16'hBEEF || o.err !== 1'b0 || o.rsp_addr !== 14'd16383) begin
            n_mismatched++;
            $display("[TB] FAIL top_rd: got rdata=%h err=%b addr=%0d expected BEEF/0/16383",
                     o.rdata, o.err, o.rsp_addr);
        end
    endtask

    task automatic test_random();
        obs_t        o;
        logic        we;
        logic [15:0] addr, wdata, exp_rdata;
        logic        exp_err;
        int          kind, stall;
        for (int n = 0; n < 60; n++) begin
            kind  = $urandom_range(0, 9);
            we    = 1'($urandom_range(0, 1));
            wdata = 16'($urandom);
            stall = $urandom_range(0, 2);
            if (kind == 0)      addr = 16'h8000 + 16'($urandom_range(0, 16383) * 2);
            else if (kind == 1) addr = 16'($urandom_range(0, 32766) * 2 + 1);
            else if (kind == 2) addr = 16'h7FFE;
            else                addr = 16'($urandom_range(0, 15) * 2);
            exp_err   = model_is_err(addr);
            exp_rdata = model_rdata(we, addr);
            do_txn(we, addr, wdata, stall, o);
            model_apply(we, addr, wdata);
            n_compared++;
            if (o.got_rsp !== 1'b1 || o.err !== exp_err || o.rdata !== exp_rdata) begin
                n_mismatched++;
                $display("[TB] FAIL rand_rsp[%0d] addr=%h we=%b: got rsp=%b err=%b rdata=%h expected 1/%b/%h",
                         n, addr, we, o.got_rsp, o.err, o.rdata, exp_err, exp_rdata);
            end
            n_compared++;
            if (o.we_seen !== (we && !exp_err) || o.addr_seen !== addr[14:1] ||
                o.stable !== 1'b1 || o.idle_after !== 1'b1) begin
                n_mismatched++;
                $display("[TB] FAIL rand_ctl[%0d] addr=%h: got we=%b waddr=%0d stable=%b idle=%b expected %b/%0d/1/1",
                         n, addr, o.we_seen, o.addr_seen, o.stable, o.idle_after,
                         we && !exp_err, addr[14:1]);
            end
            n_compared++;
            if (err_count !== 16'(exp_err_count)) begin
                n_mismatched++;
                $display("[TB] FAIL rand_count[%0d]: got %0d expected %0d", n, err_count, exp_err_count);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) begin
            mem[i]     = 16'd0;
            ref_mem[i] = 16'd0;
        end
        test_reset();
        test_write_read();
        test_stall();
        test_misaligned();
        test_out_of_range();
        test_reset_abort();
        test_top_word();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter DATA_W, default 16, data width of the request, the response and the memory word.
REQ-002 Parameter ADDR_W, default 14, memory word-address width (16384 words).
REQ-003 Port clka, input, 1, single clock; all state changes occur on its rising edge.
REQ-004 Port rsta, input, 1, reset; asynchronous and active-high.
REQ-005 Port req_valid, input, 1, processor request present.
REQ-006 Port req_ready, output, 1, unit accepts a request this cycle.
REQ-007 Port req_we, input, 1, 1 = write request, 0 = read request.
REQ-008 Port req_addr, input, 16, byte address.
REQ-009 Port req_wdata, input, DATA_W, write data.
REQ-010 Port rsp_valid, output, 1, response present.
REQ-011 Port rsp_ready, input, 1, consumer takes the response this cycle.
REQ-012 Port rsp_rdata, output, DATA_W, read data; 0 for writes and for errors.
REQ-013 Port rsp_err, output, 1, request was rejected.
REQ-014 Port err_count, output, 16, count of rejected requests; saturates at 16'hFFFF.
REQ-015 Port mem_we, output, 1, drives the memory write enable.
REQ-016 Port mem_addr, output, ADDR_W, drives the memory address.
REQ-017 Port mem_din, output, DATA_W, drives the memory write data.
REQ-018 Port mem_dout, input, DATA_W, memory read data; registered in the memory, valid 1 cycle after the address.

Function
REQ-019 A request SHALL be accepted on a rising edge where req_valid and req_ready are both 1.
REQ-020 The word address SHALL be req_addr[14:1].
REQ-021 A request SHALL be an error when req_addr[0]=1 (misaligned) or req_addr[15]=1 (out of range).
REQ-022 The state machine SHALL have three states: IDLE, RD_DATA and RSP.
REQ-023 In IDLE, req_ready SHALL be 1 and rsp_valid SHALL be 0.
REQ-024 In IDLE, mem_addr and mem_din SHALL follow the request combinationally.
REQ-025 mem_we SHALL equal req_valid AND req_we AND NOT error AND NOT rsta, and SHALL be 0 in every other state.
REQ-026 Accepting a valid read SHALL move the unit to RD_DATA.
REQ-027 Accepting a write or an error request SHALL move the unit to RSP.
REQ-028 In RSP after a write, the response SHALL be rdata=0, err=0.
REQ-029 In RSP after an error, the response SHALL be rdata=0, err=1, and err_count SHALL increment at acceptance.
REQ-030 Outside IDLE, mem_addr SHALL hold the registered accepted word address, so that mem_dout stays stable.
REQ-031 In RD_DATA, rsp_valid SHALL be 1, rsp_rdata SHALL equal mem_dout and rsp_err SHALL be 0; read latency is 1 cycle from acceptance.
REQ-032 In RD_DATA, rsp_ready=1 SHALL return the unit to IDLE.
REQ-033 In RD_DATA, rsp_ready=0 SHALL capture mem_dout into a hold register and move the unit to RSP.
REQ-034 In RSP, rsp_valid SHALL be 1 and the response SHALL be driven from the hold registers, stable until taken.
REQ-035 In RSP, rsp_ready=1 SHALL return the unit to IDLE.
REQ-036 req_ready SHALL be 0 outside IDLE; one transaction is outstanding at most, giving a peak throughput of 1 per 2 cycles.
REQ-037 Word address 16383 SHALL be valid; there is no wrap-around, because addresses at or above 0x8000 are errors.

Reset
REQ-038 While rsta is asserted, the unit SHALL be in IDLE with rsp_valid=0, rsp_err=0, rsp_rdata=0, err_count=0, mem_we=0, and the hold and address registers at 0.
REQ-039 Reset asserted in RD_DATA or RSP SHALL abort the transaction, drop its response and return the unit to IDLE asynchronously.

Structure
REQ-040 A shared package mem_access_pkg SHALL hold the state encoding, DATA_W, ADDR_W and the error-check constants.
REQ-041 A sub-module mem_rsp_hold SHALL implement the one-entry response hold register (rdata, err, load enable).

Verification
REQ-042 Write 420 to 0x0004, then read 0x0004 with rsp_ready=1 -> mem_we pulse at word 2; read response 420 one cycle after acceptance.
REQ-043 Write 69 to 0x0008, then read 0x0008 with rsp_ready=0 for 3 cycles -> rsp_valid held high, rsp_rdata=69 stable, req_ready=0 throughout.
REQ-044 Read 0x0005 -> no mem_we pulse; rsp_err=1, rsp_rdata=0, err_count=1.
REQ-045 Write to 0x8000 -> mem_we stays 0; rsp_err=1, err_count=2; memory contents unchanged.
REQ-046 Assert rsta in RD_DATA -> rsp_valid=0 immediately, IDLE after release, next read of 0x0004 returns 420.
REQ-047 Read 0x7FFE after writing 0xBEEF there -> mem_addr=16383, response 0xBEEF, err=0.
